// File: rtl/microcode_sequencer_pkg.sv
// Shared types and constants for the microcode sequencer:
// opcodes, control-word bits and the fetch words.
package microcode_sequencer_pkg;

  localparam int STEPS    = 5;
  localparam int OPCODE_W = 4;
  localparam int STEP_W   = $clog2(STEPS);
  localparam int CW_W     = 16;

  localparam int HLT_BIT = 15;
  localparam int FI_BIT  = 0;

  typedef logic [CW_W-1:0] cw_t;

  localparam cw_t C_HLT = 16'h8000;
  localparam cw_t C_MI  = 16'h4000;
  localparam cw_t C_RI  = 16'h2000;
  localparam cw_t C_RO  = 16'h1000;
  localparam cw_t C_IO  = 16'h0800;
  localparam cw_t C_II  = 16'h0400;
  localparam cw_t C_AI  = 16'h0200;
  localparam cw_t C_AO  = 16'h0100;
  localparam cw_t C_SO  = 16'h0080;
  localparam cw_t C_SU  = 16'h0040;
  localparam cw_t C_BI  = 16'h0020;
  localparam cw_t C_OI  = 16'h0010;
  localparam cw_t C_CE  = 16'h0008;
  localparam cw_t C_CO  = 16'h0004;
  localparam cw_t C_J   = 16'h0002;
  localparam cw_t C_FI  = 16'h0001;

  localparam cw_t CW_T0 = C_CO | C_MI;
  localparam cw_t CW_T1 = C_RO | C_II | C_CE;

  localparam logic [OPCODE_W-1:0] OP_LDA = 4'b0001;
  localparam logic [OPCODE_W-1:0] OP_ADD = 4'b0010;
  localparam logic [OPCODE_W-1:0] OP_SUB = 4'b0011;
  localparam logic [OPCODE_W-1:0] OP_STA = 4'b0100;
  localparam logic [OPCODE_W-1:0] OP_LDI = 4'b0101;
  localparam logic [OPCODE_W-1:0] OP_JMP = 4'b0110;
  localparam logic [OPCODE_W-1:0] OP_JC  = 4'b0111;
  localparam logic [OPCODE_W-1:0] OP_JZ  = 4'b1000;
  localparam logic [OPCODE_W-1:0] OP_OUT = 4'b1110;
  localparam logic [OPCODE_W-1:0] OP_HLT = 4'b1111;

  typedef struct packed {
    logic last;
    cw_t  word;
  } uop_t;

endpackage

// File: rtl/microcode_sequencer_rom.sv
// Combinational microcode table:
// (opcode, step, flags) -> {last, control word}.
module microcode_rom
  import microcode_sequencer_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [STEP_W-1:0]   step,
  input  logic                carry_flag,
  input  logic                zero_flag,
  output uop_t                uop
);

  logic t2, t3, t4;
  logic has_exec;

  assign t2 = step == STEP_W'(2);
  assign t3 = step == STEP_W'(3);
  assign t4 = step == STEP_W'(4);

  always_comb begin
    unique case (opcode)
      OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI,
      OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT:
        has_exec = 1'b1;
      default:
        has_exec = 1'b0;
    endcase
  end

  // Default entry is an empty END step; untaken jumps fall to it.
  always_comb begin
    uop = '{last: 1'b1, word: '0};
    unique case (step)
      STEP_W'(0): uop = '{last: 1'b0, word: CW_T0};
      STEP_W'(1): uop = '{last: !has_exec, word: CW_T1};
      default: begin
        unique case (opcode)
          OP_LDA: begin
            if (t2) uop = '{last: 1'b0, word: C_IO | C_MI};
            else if (t3) uop.word = C_RO | C_AI;
          end
          OP_ADD: begin
            if (t2) uop = '{last: 1'b0, word: C_IO | C_MI};
            else if (t3) uop = '{last: 1'b0, word: C_RO | C_BI};
            else if (t4) uop.word = C_SO | C_AI | C_FI;
          end
          OP_SUB: begin
            if (t2) uop = '{last: 1'b0, word: C_IO | C_MI};
            else if (t3) uop = '{last: 1'b0, word: C_RO | C_BI};
            else if (t4) uop.word = C_SO | C_SU | C_AI | C_FI;
          end
          OP_STA: begin
            if (t2) uop = '{last: 1'b0, word: C_IO | C_MI};
            else if (t3) uop.word = C_AO | C_RI;
          end
          OP_LDI: if (t2) uop.word = C_IO | C_AI;
          OP_JMP: if (t2) uop.word = C_IO | C_J;
          OP_JC:  if (t2 && carry_flag) uop.word = C_IO | C_J;
          OP_JZ:  if (t2 && zero_flag) uop.word = C_IO | C_J;
          OP_OUT: if (t2) uop.word = C_AO | C_OI;
          OP_HLT: if (t2) uop.word = C_HLT;
          default: ;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/microcode_sequencer.sv
// T-state sequencer: step counter, CF/ZF register, sticky
// halt and run/single-step gating around the microcode table.
module microcode_sequencer
  import microcode_sequencer_pkg::*;
(
  input  logic                clk,
  input  logic                clr,
  input  logic                run,
  input  logic                step_req,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                alu_carry,
  input  logic                alu_zero,
  output logic [CW_W-1:0]     ctrl_word,
  output logic [STEP_W-1:0]   step,
  output logic                carry_flag,
  output logic                zero_flag,
  output logic                halted
);

  logic [STEP_W-1:0] step_q, step_d;
  logic              cf_q, cf_d;
  logic              zf_q, zf_d;
  logic              halted_q, halted_d;
  logic              adv, fire;
  uop_t              uop;

  microcode_rom u_rom (
    .opcode     (opcode),
    .step       (step_q),
    .carry_flag (cf_q),
    .zero_flag  (zf_q),
    .uop        (uop)
  );

  assign adv  = run | step_req;
  assign fire = adv & ~halted_q;

  always_comb begin
    step_d    = step_q;
    cf_d      = cf_q;
    zf_d      = zf_q;
    halted_d  = halted_q;
    ctrl_word = '0;
    // Gate on clr so no partial write escapes during reset.
    if (!clr) ctrl_word = '0;
    else if (halted_q) ctrl_word = C_HLT;
    else if (adv) ctrl_word = uop.word;
    if (fire) begin
      if (uop.word[HLT_BIT]) begin
        halted_d = 1'b1;
      end else if (uop.last || step_q == STEP_W'(STEPS-1)) begin
        step_d = '0;
      end else begin
        step_d = step_q + STEP_W'(1);
      end
      if (uop.word[FI_BIT]) begin
        cf_d = alu_carry;
        zf_d = alu_zero;
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      step_q   <= '0;
      cf_q     <= 1'b0;
      zf_q     <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      cf_q     <= cf_d;
      zf_q     <= zf_d;
      halted_q <= halted_d;
    end
  end

  assign step       = step_q;
  assign carry_flag = cf_q;
  assign zero_flag  = zf_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: directed scenarios plus
// random run/step traffic against an instruction-level model.
module tb_microcode_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic        run;
  logic        step_req;
  logic [3:0]  opcode;
  logic        alu_carry;
  logic        alu_zero;
  logic [15:0] ctrl_word;
  logic [2:0]  step;
  logic        carry_flag;
  logic        zero_flag;
  logic        halted;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] prog [16][5];
  int          plen [16];

  int m_step;
  bit m_cf, m_zf, m_halt;

  logic [3:0] cur_op;

  always #5 clk = ~clk;

  microcode_sequencer dut (
    .clk        (clk),
    .clr        (clr),
    .run        (run),
    .step_req   (step_req),
    .opcode     (opcode),
    .alu_carry  (alu_carry),
    .alu_zero   (alu_zero),
    .ctrl_word  (ctrl_word),
    .step       (step),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .halted     (halted)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Instruction sequences as lists of words, T0 first.
  task automatic build_prog();
    for (int op = 0; op < 16; op++) begin
      plen[op] = 2;
      prog[op][0] = 16'h4004;
      prog[op][1] = 16'h1408;
      for (int t = 2; t < 5; t++) prog[op][t] = 16'h0000;
    end
    plen[1]  = 4; prog[1][2]  = 16'h4800; prog[1][3] = 16'h1200;
    plen[2]  = 5; prog[2][2]  = 16'h4800; prog[2][3] = 16'h1020;
    prog[2][4] = 16'h0281;
    plen[3]  = 5; prog[3][2]  = 16'h4800; prog[3][3] = 16'h1020;
    prog[3][4] = 16'h02C1;
    plen[4]  = 4; prog[4][2]  = 16'h4800; prog[4][3] = 16'h2100;
    plen[5]  = 3; prog[5][2]  = 16'h0A00;
    plen[6]  = 3; prog[6][2]  = 16'h0802;
    plen[7]  = 3; prog[7][2]  = 16'h0802;
    plen[8]  = 3; prog[8][2]  = 16'h0802;
    plen[14] = 3; prog[14][2] = 16'h0110;
    plen[15] = 3; prog[15][2] = 16'h8000;
  endtask

  function automatic logic [15:0] m_word();
    if (m_step >= plen[opcode]) return 16'h0000;
    if (m_step == 2 && ((opcode == 4'h7 && !m_cf) ||
                        (opcode == 4'h8 && !m_zf)))
      return 16'h0000;
    return prog[opcode][m_step];
  endfunction

  function automatic logic [15:0] exp_cw();
    if (!clr) return 16'h0000;
    if (m_halt) return 16'h8000;
    if (run || step_req) return m_word();
    return 16'h0000;
  endfunction

  task automatic m_reset();
    m_step = 0;
    m_cf   = 1'b0;
    m_zf   = 1'b0;
    m_halt = 1'b0;
  endtask

  task automatic model_edge();
    logic [15:0] w;
    bit          last;
    if (clr && (run || step_req) && !m_halt) begin
      w    = m_word();
      last = (m_step == plen[opcode] - 1) || (m_step == 4);
      if (w[0]) begin
        m_cf = alu_carry;
        m_zf = alu_zero;
      end
      if (w[15]) m_halt = 1'b1;
      else m_step = last ? 0 : m_step + 1;
    end
  endtask

  task automatic compare_all();
    check("ctrl_word", {16'h0, ctrl_word}, {16'h0, exp_cw()});
    check("step", {29'h0, step}, m_step);
    check("carry_flag", {31'h0, carry_flag}, {31'h0, m_cf});
    check("zero_flag", {31'h0, zero_flag}, {31'h0, m_zf});
    check("halted", {31'h0, halted}, {31'h0, m_halt});
  endtask

  task automatic drive(input logic r, input logic s,
                       input logic [3:0] op,
                       input logic c, input logic z);
    run       = r;
    step_req  = s;
    opcode    = op;
    alu_carry = c;
    alu_zero  = z;
    #1;
    compare_all();
  endtask

  task automatic clk_edge();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic tick(input logic r, input logic s,
                      input logic [3:0] op,
                      input logic c, input logic z);
    drive(r, s, op, c, z);
    clk_edge();
  endtask

  task automatic do_reset();
    clr = 1'b0;
    m_reset();
    #1;
    compare_all();
    @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
  endtask

  initial begin
    build_prog();
    m_reset();
    clr = 1'b0; run = 1'b0; step_req = 1'b0;
    opcode = 4'h0; alu_carry = 1'b0; alu_zero = 1'b0;
    cur_op = 4'h0;
    @(negedge clk);
    do_reset();
    check("reset_cw", {16'h0, ctrl_word}, 32'h0);

    // LDA free-run: four words then back to T0
    drive(1, 0, 4'h1, 0, 0);
    check("lda_t0", {16'h0, ctrl_word}, 32'h4004);
    clk_edge();
    drive(1, 0, 4'h1, 0, 0);
    check("lda_t1", {16'h0, ctrl_word}, 32'h1408);
    clk_edge();
    drive(1, 0, 4'h1, 0, 0);
    check("lda_t2", {16'h0, ctrl_word}, 32'h4800);
    clk_edge();
    drive(1, 0, 4'h1, 0, 0);
    check("lda_t3", {16'h0, ctrl_word}, 32'h1200);
    clk_edge();
    drive(1, 0, 4'h1, 0, 0);
    check("lda_wrap", {29'h0, step}, 32'h0);

    // ADD with carry out, then taken JC
    for (int t = 0; t < 4; t++) tick(1, 0, 4'h2, 1, 0);
    drive(1, 0, 4'h2, 1, 0);
    check("add_t4", {16'h0, ctrl_word}, 32'h0281);
    clk_edge();
    drive(1, 0, 4'h7, 0, 0);
    check("add_cf", {31'h0, carry_flag}, 32'h1);
    clk_edge();
    tick(1, 0, 4'h7, 0, 0);
    drive(1, 0, 4'h7, 0, 0);
    check("jc_taken", {16'h0, ctrl_word}, 32'h0802);
    clk_edge();
    drive(1, 0, 4'h7, 0, 0);
    check("jc_end", {29'h0, step}, 32'h0);

    // Reset in the middle of ADD T3
    for (int t = 0; t < 3; t++) tick(1, 0, 4'h2, 1, 1);
    drive(1, 0, 4'h2, 1, 1);
    clr = 1'b0;
    m_reset();
    #1;
    check("rst_cw", {16'h0, ctrl_word}, 32'h0);
    check("rst_step", {29'h0, step}, 32'h0);
    check("rst_cf", {31'h0, carry_flag}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    drive(1, 0, 4'h7, 0, 0);
    check("rel_t0", {16'h0, ctrl_word}, 32'h4004);
    clk_edge();
    tick(1, 0, 4'h7, 0, 0);
    drive(1, 0, 4'h7, 0, 0);
    check("jc_untaken", {16'h0, ctrl_word}, 32'h0);
    clk_edge();
    drive(1, 0, 4'h7, 0, 0);
    check("jc_nt_end", {29'h0, step}, 32'h0);

    // Single-step: idle, then three pulses
    for (int i = 0; i < 10; i++) tick(0, 0, 4'h1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 4'h1, 0, 0);
      tick(0, 0, 4'h1, 0, 0);
    end
    check("ss_three", {29'h0, step}, 32'h3);
    tick(1, 0, 4'h1, 0, 0);

    // HLT latches and ignores run/step_req
    tick(1, 0, 4'hF, 0, 0);
    tick(1, 0, 4'hF, 0, 0);
    drive(1, 0, 4'hF, 0, 0);
    check("hlt_t2", {16'h0, ctrl_word}, 32'h8000);
    clk_edge();
    for (int i = 0; i < 6; i++)
      tick(1'($urandom), 1'($urandom), 4'h1, 1, 1);
    check("hlt_step", {29'h0, step}, 32'h2);
    check("hlt_flag", {31'h0, halted}, 32'h1);
    do_reset();
    check("hlt_clr", {31'h0, halted}, 32'h0);

    // NOP and an undefined opcode end at T1
    tick(1, 0, 4'h0, 1, 1);
    tick(1, 0, 4'h0, 1, 1);
    drive(1, 0, 4'hA, 1, 1);
    check("nop_end", {29'h0, step}, 32'h0);
    clk_edge();
    tick(1, 0, 4'hA, 1, 1);
    drive(0, 0, 4'hA, 1, 1);
    check("undef_end", {29'h0, step}, 32'h0);
    check("undef_cf", {31'h0, carry_flag}, 32'h0);
    clk_edge();

    // Random traffic; opcode only changes at T0
    for (int i = 0; i < 3000; i++) begin
      if (m_step == 0) cur_op = 4'($urandom_range(0, 15));
      if ((m_halt && $urandom_range(0, 7) == 0) ||
          $urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        tick($urandom_range(0, 3) != 0, 1'($urandom), cur_op,
             1'($urandom), 1'($urandom));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
